// File: rtl/ascon_round_sequencer.sv
// ASCON permutation round sequencer: owns the 320-bit state and round counter,
// and steps an external combinational round datapath for p^a / p^b.
module ascon_round_sequencer #(
   parameter int MAX_ROUNDS = 12,
   parameter int RCNT_W     = 4
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [RCNT_W-1:0] rounds_i,
   input  logic [319:0]      state_i,
   input  logic              hold_i,
   input  logic [319:0]      perm_state_i,
   output logic [RCNT_W-1:0] round_o,
   output logic [319:0]      state_o,
   output logic              ready_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [RCNT_W-1:0] C_MAX  = RCNT_W'(MAX_ROUNDS);
   localparam logic [RCNT_W-1:0] C_LAST = RCNT_W'(MAX_ROUNDS - 1);
   localparam logic [RCNT_W-1:0] C_ONE  = RCNT_W'(1);

   logic [1:0]        r_fsm;
   logic [RCNT_W-1:0] r_cnt;
   logic [319:0]      r_state;
   logic [RCNT_W-1:0] w_rounds;
   logic [RCNT_W-1:0] w_first;

   // p^b runs the tail of the p^a constant schedule, so start at MAX-r
   always_comb begin
      w_rounds = rounds_i;
      if (rounds_i == '0 || rounds_i > C_MAX) begin
         w_rounds = C_MAX;
      end
      w_first = C_MAX - w_rounds;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_fsm   <= ST_IDLE;
         r_cnt   <= '0;
         r_state <= '0;
      end else begin
         case (r_fsm)
            ST_IDLE: begin
               if (start_i) begin
                  r_state <= state_i;
                  r_cnt   <= w_first;
                  r_fsm   <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!hold_i) begin
                  r_state <= perm_state_i;
                  if (r_cnt == C_LAST) begin
                     r_fsm <= ST_DONE;
                  end else begin
                     r_cnt <= r_cnt + C_ONE;
                  end
               end
            end
            ST_DONE: r_fsm <= ST_IDLE;
            default: r_fsm <= ST_IDLE;
         endcase
      end
   end

   assign round_o = r_cnt;
   assign state_o = r_state;
   assign ready_o = (r_fsm == ST_IDLE);
   assign busy_o  = (r_fsm == ST_RUN);
   assign done_o  = (r_fsm == ST_DONE);

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Directed bench for ascon_round_sequencer; the round datapath is a
// behavioural ASCON round driven from state_o/round_o.
module tb_ascon_round_sequencer;

   logic         clk;
   logic         reset;
   logic         start;
   logic [3:0]   rounds;
   logic [319:0] st_in;
   logic         hold;
   logic [319:0] perm_state;
   logic [3:0]   round_o;
   logic [319:0] state_o;
   logic         ready_o;
   logic         busy_o;
   logic         done_o;

   int errors = 0;
   int checks = 0;

   localparam logic [319:0] IV_ST = {
      64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
      64'h1011121314151617, 64'h18191a1b1c1d1e1f};
   localparam logic [319:0] ST_B = {
      64'hdeadbeefcafef00d, 64'h0123456789abcdef, 64'hfedcba9876543210,
      64'h5555aaaa5555aaaa, 64'h0f0f0f0ff0f0f0f0};

   ascon_round_sequencer dut (
      .clock_i      (clk),
      .reset_i      (reset),
      .start_i      (start),
      .rounds_i     (rounds),
      .state_i      (st_in),
      .hold_i       (hold),
      .perm_state_i (perm_state),
      .round_o      (round_o),
      .state_o      (state_o),
      .ready_o      (ready_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ror(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [319:0] ascon_round(input logic [319:0] s,
                                                input logic [3:0] i);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      logic [3:0]  hi;
      {x0, x1, x2, x3, x4} = s;
      hi = 4'hF - i;
      x2 = x2 ^ {56'd0, hi, i};
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3;
      t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3;
      x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
      return {x0, x1, x2, x3, x4};
   endfunction

   always_comb perm_state = ascon_round(state_o, round_o);

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; rounds = 4'd12; st_in = '1; hold = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if ({ready_o, busy_o, done_o, round_o} !== 7'b100_0000) begin
            errors++;
            $display("FAIL reset_flags c=%0d got=%b exp=%b", c,
                     {ready_o, busy_o, done_o, round_o}, 7'b100_0000);
         end
         checks++;
         if (state_o !== 320'd0) begin
            errors++;
            $display("FAIL reset_state c=%0d got=%h exp=0", c, state_o);
         end
      end
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_pa();
      logic [319:0] exp;
      rounds = 4'd12; st_in = IV_ST; start = 1'b1;
      @(negedge clk);
      start = 1'b0; rounds = 4'd3; st_in = ST_B;
      exp = IV_ST;
      for (int k = 0; k < 12; k++) begin
         checks++;
         if ({ready_o, busy_o, done_o, round_o} !== {3'b010, 4'(k)}) begin
            errors++;
            $display("FAIL pa_flags k=%0d got=%b exp=%b", k,
                     {ready_o, busy_o, done_o, round_o}, {3'b010, 4'(k)});
         end
         checks++;
         if (state_o !== exp) begin
            errors++;
            $display("FAIL pa_state k=%0d got=%h exp=%h", k, state_o, exp);
         end
         exp = ascon_round(exp, 4'(k));
         @(negedge clk);
      end
      checks++;
      if ({ready_o, busy_o, done_o} !== 3'b001 || state_o !== exp) begin
         errors++;
         $display("FAIL pa_done got=%b/%h exp=001/%h",
                  {ready_o, busy_o, done_o}, state_o, exp);
      end
      @(negedge clk);
      checks++;
      if ({ready_o, busy_o, done_o} !== 3'b100 || state_o !== exp) begin
         errors++;
         $display("FAIL pa_idle got=%b/%h exp=100/%h",
                  {ready_o, busy_o, done_o}, state_o, exp);
      end
   endtask

   task automatic test_pb();
      logic [319:0] exp;
      int r;
      int first;
      for (int t = 0; t < 2; t++) begin
         r = (t == 0) ? 6 : 8;
         first = 12 - r;
         rounds = 4'(r); st_in = ST_B ^ 320'(t); start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         exp = ST_B ^ 320'(t);
         for (int k = 0; k < r; k++) begin
            checks++;
            if ({busy_o, done_o, round_o} !== {2'b10, 4'(first + k)}) begin
               errors++;
               $display("FAIL pb%0d_round k=%0d got=%b exp=%b", r, k,
                        {busy_o, done_o, round_o}, {2'b10, 4'(first + k)});
            end
            exp = ascon_round(exp, 4'(first + k));
            @(negedge clk);
         end
         checks++;
         if ({ready_o, busy_o, done_o} !== 3'b001 || state_o !== exp) begin
            errors++;
            $display("FAIL pb%0d_done got=%b/%h exp=001/%h", r,
                     {ready_o, busy_o, done_o}, state_o, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_clamp_hold();
      logic [319:0] exp;
      rounds = 4'd0; st_in = IV_ST; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp = IV_ST;
      for (int k = 0; k < 12; k++) begin
         checks++;
         if ({busy_o, done_o, round_o} !== {2'b10, 4'(k)} || state_o !== exp) begin
            errors++;
            $display("FAIL clamp_round k=%0d got=%b exp=%b", k,
                     {busy_o, done_o, round_o}, {2'b10, 4'(k)});
         end
         if (k == 5) begin
            hold = 1'b1;
            for (int h = 0; h < 3; h++) begin
               @(negedge clk);
               checks++;
               if ({busy_o, done_o, round_o} !== 6'b10_0101 || state_o !== exp) begin
                  errors++;
                  $display("FAIL hold_frozen h=%0d got=%b/%h exp=100101/%h", h,
                           {busy_o, done_o, round_o}, state_o, exp);
               end
            end
            hold = 1'b0;
         end
         exp = ascon_round(exp, 4'(k));
         @(negedge clk);
      end
      checks++;
      if ({ready_o, busy_o, done_o} !== 3'b001 || state_o !== exp) begin
         errors++;
         $display("FAIL clamp_done got=%b/%h exp=001/%h",
                  {ready_o, busy_o, done_o}, state_o, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [319:0] exp;
      rounds = 4'd8; st_in = IV_ST; start = 1'b1;
      @(negedge clk);
      rounds = 4'd6; st_in = ST_B;
      exp = IV_ST;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if ({busy_o, done_o, round_o} !== {2'b10, 4'(4 + k)} || state_o !== exp) begin
            errors++;
            $display("FAIL coll_round k=%0d got=%b exp=%b", k,
                     {busy_o, done_o, round_o}, {2'b10, 4'(4 + k)});
         end
         exp = ascon_round(exp, 4'(4 + k));
         @(negedge clk);
      end
      checks++;
      if ({ready_o, busy_o, done_o} !== 3'b001 || state_o !== exp) begin
         errors++;
         $display("FAIL coll_done got=%b/%h exp=001/%h",
                  {ready_o, busy_o, done_o}, state_o, exp);
      end
      @(negedge clk);
      checks++;
      if ({ready_o, busy_o, done_o} !== 3'b100 || state_o !== exp) begin
         errors++;
         $display("FAIL coll_idle got=%b/%h exp=100/%h",
                  {ready_o, busy_o, done_o}, state_o, exp);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({busy_o, round_o} !== 5'b1_0110 || state_o !== ST_B) begin
         errors++;
         $display("FAIL b2b_accept got=%b/%h exp=10110/%h",
                  {busy_o, round_o}, state_o, ST_B);
      end
      exp = ST_B;
      for (int k = 0; k < 6; k++) begin
         exp = ascon_round(exp, 4'(6 + k));
         @(negedge clk);
      end
      checks++;
      if ({ready_o, busy_o, done_o} !== 3'b001 || state_o !== exp) begin
         errors++;
         $display("FAIL b2b_done got=%b/%h exp=001/%h",
                  {ready_o, busy_o, done_o}, state_o, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_abort();
      logic [319:0] exp;
      rounds = 4'd12; st_in = ST_B; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      checks++;
      if ({busy_o, round_o} !== 5'b1_0111) begin
         errors++;
         $display("FAIL abort_pre got=%b exp=10111", {busy_o, round_o});
      end
      reset = 1'b1; start = 1'b1;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      checks++;
      if ({ready_o, busy_o, done_o, round_o} !== 7'b100_0000 || state_o !== 320'd0) begin
         errors++;
         $display("FAIL abort_idle got=%b/%h exp=1000000/0",
                  {ready_o, busy_o, done_o, round_o}, state_o);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({ready_o, busy_o, done_o} !== 3'b100) begin
            errors++;
            $display("FAIL abort_nodone c=%0d got=%b exp=100", c,
                     {ready_o, busy_o, done_o});
         end
      end
      rounds = 4'd6; st_in = IV_ST; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp = IV_ST;
      for (int k = 0; k < 6; k++) begin
         exp = ascon_round(exp, 4'(6 + k));
         @(negedge clk);
      end
      checks++;
      if ({ready_o, busy_o, done_o} !== 3'b001 || state_o !== exp) begin
         errors++;
         $display("FAIL abort_rerun got=%b/%h exp=001/%h",
                  {ready_o, busy_o, done_o}, state_o, exp);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_pa();
      test_pb();
      test_clamp_hold();
      test_back_to_back();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
